// File: rtl/hcmpp_bram.sv
// True dual-port HCM row RAM, single clock, 1-cycle read latency.
// Define HCMPP_BRAM_OUTREG_EN to add an output register stage (2-cycle latency).
module hcmpp_bram #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  logic w_wr_a;
  logic w_wr_b;
  logic [DATA_WIDTH-1:0] r_douta;
  logic [DATA_WIDTH-1:0] r_doutb;

  assign w_wr_a = ena & wea & ~reset;
  assign w_wr_b = enb & web & ~reset;

  // Port A is applied last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (w_wr_b) r_mem[addrb] <= dinb;
    if (w_wr_a) r_mem[addra] <= dina;
  end

  // Own write is forwarded (write-first); the other port's write is not yet
  // visible in r_mem at this edge, which gives read-first across ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_douta <= '0;
    end else if (ena) begin
      if (wea) r_douta <= dina;
      else     r_douta <= r_mem[addra];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_doutb <= '0;
    end else if (enb) begin
      if (web) r_doutb <= dinb;
      else     r_doutb <= r_mem[addrb];
    end
  end

`ifdef HCMPP_BRAM_OUTREG_EN
  logic r_vld_a;
  logic r_vld_b;
  logic [DATA_WIDTH-1:0] r_douta_q;
  logic [DATA_WIDTH-1:0] r_doutb_q;

  // Second stage only advances behind an enabled access, so idle cycles hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_a   <= 1'b0;
      r_vld_b   <= 1'b0;
      r_douta_q <= '0;
      r_doutb_q <= '0;
    end else begin
      r_vld_a <= ena;
      r_vld_b <= enb;
      if (r_vld_a) r_douta_q <= r_douta;
      if (r_vld_b) r_doutb_q <= r_doutb;
    end
  end

  assign douta = r_douta_q;
  assign doutb = r_doutb_q;
`else
  assign douta = r_douta;
  assign doutb = r_doutb;
`endif

endmodule

// File: tb/tb_hcmpp_bram.sv
// Bench for hcmpp_bram: directed vector table, corner sequences, randomized model check.
module tb_hcmpp_bram;

`ifdef HCMPP_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ena, wea, enb, web;
  logic [9:0]  addra, addrb;
  logic [10:0] dina, dinb;
  logic [10:0] douta, doutb;

  int tests = 0;
  int fails = 0;

  hcmpp_bram #(.DATA_WIDTH(11), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ena, wea;
    logic [9:0]  addra;
    logic [10:0] dina;
    logic        enb, web;
    logic [9:0]  addrb;
    logic [10:0] dinb;
    logic        ca;
    logic [10:0] ea;
    logic        cb;
    logic [10:0] eb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string n, logic a_en, logic a_we, int a_ad, int a_d,
                              logic b_en, logic b_we, int b_ad, int b_d,
                              logic ca, int ea, logic cb, int eb);
    vec_t v;
    v.name = n;
    v.ena = a_en; v.wea = a_we; v.addra = 10'(a_ad); v.dina = 11'(a_d);
    v.enb = b_en; v.web = b_we; v.addrb = 10'(b_ad); v.dinb = 11'(b_d);
    v.ca = ca; v.ea = 11'(ea); v.cb = cb; v.eb = 11'(eb);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
  endtask

  task automatic check(string n, logic [10:0] act, logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", n, act, exp);
    end
  endtask

  logic [10:0] mdl [1024];
  logic [10:0] ra[$];
  logic [10:0] rb[$];
  logic [10:0] seq_exp [3];

  initial begin
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    idle();
    reset = 1'b1;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    step(); step();
    check("reset_douta", douta, 11'h000);
    check("reset_doutb", doutb, 11'h000);
    reset = 1'b0;

    //            name        ena wea  aA    dA     enb web  aB    dB     ca  ea     cb  eb
    vt.push_back(mk("wr_a5",    1, 1,    5, 'h123,  0, 0,    0, 0,     1, 'h123, 0, 0));
    vt.push_back(mk("rd_b5",    0, 0,    0, 0,      1, 0,    5, 'h3FF, 0, 0,     1, 'h123));
    vt.push_back(mk("pre_a7",   1, 1,    7, 'h011,  0, 0,    0, 0,     1, 'h011, 0, 0));
    vt.push_back(mk("coll_7",   1, 1,    7, 'h0AA,  1, 0,    7, 'h555, 1, 'h0AA, 1, 'h011));
    vt.push_back(mk("after_7",  0, 0,    0, 0,      1, 0,    7, 0,     0, 0,     1, 'h0AA));
    vt.push_back(mk("wf_a3",    1, 1,    3, 'h7FF,  0, 0,    0, 0,     1, 'h7FF, 0, 0));
    vt.push_back(mk("dbl_9",    1, 1,    9, 'h001,  1, 1,    9, 'h002, 1, 'h001, 1, 'h002));
    vt.push_back(mk("dbl_rd9",  0, 0,    0, 0,      1, 0,    9, 0,     0, 0,     1, 'h001));
    vt.push_back(mk("gate_a4",  0, 1,    4, 'h055,  0, 0,    0, 0,     1, 'h001, 0, 0));
    vt.push_back(mk("gate_rd4", 0, 0,    0, 0,      1, 0,    4, 0,     1, 'h001, 1, 'h000));
    vt.push_back(mk("rd_a9",    1, 0,    9, 'h2AA,  0, 0,    0, 0,     1, 'h001, 0, 0));
    vt.push_back(mk("wr_max",   1, 1, 1023, 'h555,  0, 0,    0, 0,     1, 'h555, 0, 0));
    vt.push_back(mk("rd_max",   0, 0,    0, 0,      1, 0, 1023, 0,     1, 'h555, 1, 'h555));
    vt.push_back(mk("wf_b0",    0, 0,    0, 0,      1, 1,    0, 'h2C3, 0, 0,     1, 'h2C3));
    vt.push_back(mk("rd_a0",    1, 0,    0, 0,      0, 0,    0, 0,     1, 'h2C3, 0, 0));

    foreach (vt[i]) begin
      ena = vt[i].ena; wea = vt[i].wea; addra = vt[i].addra; dina = vt[i].dina;
      enb = vt[i].enb; web = vt[i].web; addrb = vt[i].addrb; dinb = vt[i].dinb;
      step();
      idle();
      for (int k = 1; k < LAT; k++) step();
      if (vt[i].ca) check({vt[i].name, "_a"}, douta, vt[i].ea);
      if (vt[i].cb) check({vt[i].name, "_b"}, doutb, vt[i].eb);
    end

    // Back-to-back reads on port B, one per cycle.
    seq_exp[0] = 11'h123; seq_exp[1] = 11'h0AA; seq_exp[2] = 11'h001;
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      enb = (i < 3); web = 1'b0;
      addrb = (i == 0) ? 10'd5 : (i == 1) ? 10'd7 : 10'd9;
      step();
      if (i - (LAT - 1) >= 0) check("b2b_rd", doutb, seq_exp[i - (LAT - 1)]);
    end
    idle();
    step();

    // Reset arriving behind a read; writes attempted during reset must be blocked.
    enb = 1'b1; web = 1'b0; addrb = 10'd5;
    step();
    enb = 1'b0;
    reset = 1'b1;
    ena = 1'b1; wea = 1'b1; addra = 10'd6; dina = 11'h3C3;
    step();
    check("rst_doutb", doutb, 11'h000);
    check("rst_douta", douta, 11'h000);
    idle();
    step();
    check("rst_hold_b", doutb, 11'h000);
    reset = 1'b0;
    enb = 1'b1; addrb = 10'd5;
    ena = 1'b1; wea = 1'b0; addra = 10'd6;
    step();
    idle();
    for (int k = 1; k < LAT; k++) step();
    check("post_rst_rd5", doutb, 11'h123);
    check("rst_wr_blocked", douta, 11'h000);

    // Randomized traffic on a small address window to provoke collisions.
    for (int t = 0; t < 400; t++) begin
      logic [10:0] va, vb;
      ena = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      enb = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wea = 1'($urandom_range(0, 1));
      web = 1'($urandom_range(0, 1));
      addra = 10'(16 + $urandom_range(0, 7));
      addrb = 10'(16 + $urandom_range(0, 7));
      dina = 11'($urandom_range(0, 2047));
      dinb = 11'($urandom_range(0, 2047));
      va = wea ? dina : mdl[addra];
      vb = web ? dinb : mdl[addrb];
      ra.push_back(ena ? va : ra[$]);
      rb.push_back(enb ? vb : rb[$]);
      if (enb && web) mdl[addrb] = dinb;
      if (ena && wea) mdl[addra] = dina;
      step();
      if (t >= LAT - 1) begin
        check("rand_a", douta, ra[t - (LAT - 1)]);
        check("rand_b", doutb, rb[t - (LAT - 1)]);
      end
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hcmpp_bram.md
Name: hcmpp_bram

Overview:
- True dual-port synchronous block RAM that holds the hit-count map (HCM) for the HCM pattern-processing engine.
- Each row stores a packed word: hit count in the low bits, hit-info-memory (HIM) address in the high bits.
- Port A is the engine's write port (read-modify-write target). Port B is its row-read port.
- Both ports run on one clock with a fixed, known read latency so the engine's wait-time queues can track outstanding reads.

Parameters:
- DATA_WIDTH, 11, row word width in bits (NCOLS_HCM).
- ADDR_WIDTH, 10, address bits (ROWINDEXBITS_HCM); depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock shared by both ports (replaces clka/clkb).
- reset  input  1  synchronous, active-high reset.
- ena  input  1  port A enable.
- wea  input  1  port A write enable.
- addra  input  ADDR_WIDTH  port A address.
- dina  input  DATA_WIDTH  port A write data.
- douta  output  DATA_WIDTH  port A read data.
- enb  input  1  port B enable.
- web  input  1  port B write enable.
- addrb  input  ADDR_WIDTH  port B address.
- dinb  input  DATA_WIDTH  port B write data.
- doutb  output  DATA_WIDTH  port B read data.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Memory contents initialise to all zeros at configuration. Reset does not clear the array.
- Reset clears all output pipeline registers, so douta = doutb = 0 on the cycle after reset is sampled.
- Any read in flight during reset is discarded.
- While reset is high, writes on both ports are blocked.
- Port access: on a rising edge with enX = 1, the port samples addrX. If weX = 1, it writes dinX to mem[addrX].
- Read latency is 1 cycle by default: data for an address sampled at edge N appears on doutX after edge N+1 and holds until the next enabled access.
- With enX = 0, the port does nothing: no write, and doutX holds its value.
- Same-port write mode is write-first: on an enabled write, doutX shows the newly written data after the read latency.
- Cross-port collision, one port writes and the other reads the same address in the same cycle: the reading port returns the old contents (read-first). The new data is visible to reads issued on the next cycle or later.
  - The engine avoids depending on this case by redirecting its read.
- Double write, both ports write the same address in the same cycle: port A wins and mem holds dina.
- No address wrap logic is needed: addresses are full-range ADDR_WIDTH, and every value is valid.
- No handshake and no back-pressure: every enabled cycle accepts a new access on each port independently.
- Full throughput is one access per port per cycle.

Optional Feature:
- Macro HCMPP_BRAM_OUTREG_EN.
- When defined, an extra output register stage is added on both ports and read latency becomes 2 cycles.
  - The extra stage is cleared by reset.
  - The extra stage advances only when the port's enable was high on the access being pipelined.
- When undefined, read latency is 1 cycle.
- All collision and priority rules are unchanged. Only the latency shifts.

Test Plan:
- Basic write/read: write A addr 5 = 0x123. Next cycle read B addr 5. Then doutb = 0x123 exactly 1 cycle later (2 cycles with HCMPP_BRAM_OUTREG_EN).
- Cross-port collision: preload addr 7 = 0x011. In the same cycle write A addr 7 = 0x0AA and read B addr 7. Then doutb = 0x011; a read of addr 7 on the following cycle returns 0x0AA.
- Write-first on port A: write A addr 3 = 0x7FF. Then douta = 0x7FF after the latency.
- Double-write priority: same cycle, A writes addr 9 = 0x001 and B writes addr 9 = 0x002. A later read of addr 9 returns 0x001.
- Enable gating: ena = 0 with wea = 1 writing addr 4 = 0x055 (preloaded 0x000). A read of addr 4 returns 0x000, and douta holds its prior value throughout.
- Reset mid-operation: issue a read of addr 5 (0x123) and assert reset the next cycle. Then doutb = 0 after reset with no stale 0x123. A post-reset read of addr 5 returns 0x123 (contents retained).
